accumulate_complex: RTL and testbench
=====================================

# accumulate_complex

Complex integrate-and-dump stage downstream of `multiply_complex`. Sums blocks of 2^LOG_N consecutive complex products and emits one averaged complex sample per block. Used after the complex multiplier for correlation/despreading and decimating mixers. Uses the fpgamath streaming conventions: `in_nd`/`out_nd` strobes, metadata sideband `in_m`/`out_m`, sticky `error`.

## Interface
- WIDTH, 32: packed complex word width; real in [WIDTH-1:WIDTH/2], imag in [WIDTH/2-1:0], both two's-complement. Must be even.
- MWIDTH, 1: metadata sideband width.
- LOG_N, 2: log2 of block length; legal range 1..8.

- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  WIDTH  packed complex sample, valid when in_nd=1.
- in_nd  input  1  new-data strobe, one sample per high cycle; any gap pattern allowed.
- in_m  input  MWIDTH  metadata accompanying in_data.
- out_data  output  WIDTH  packed averaged complex result.
- out_nd  output  1  one-cycle strobe, out_data/out_m valid.
- out_m  output  MWIDTH  metadata of the first sample of the block.
- error  output  1  sticky metadata-mismatch flag.

## Operation
- Internal state: sample counter cnt (LOG_N bits), accumulators acc_re/acc_im (signed, WIDTH/2+LOG_N bits each), held metadata m_hold.
- Each in_nd: real/imag sign-extended to WIDTH/2+LOG_N bits and added.
  - cnt==0 (first sample): acc <= sample (old contents discarded); m_hold <= in_m.
  - 0<cnt<2^LOG_N-1: acc <= acc + sample.
  - cnt==2^LOG_N-1 (last): sum = acc + sample; out_data real/imag <= sum >>> LOG_N (arithmetic shift, floor rounding, low WIDTH/2 bits); out_m <= m_hold; out_nd <= 1.
  - cnt increments, wraps to 0 after the last sample.
- Average of 2^LOG_N in-range values is always in range; no saturation logic, no overflow possible.
- Metadata rule: every sample with cnt!=0 must carry in_m == m_hold; otherwise error <= 1. Sample still accumulated, block still completes normally. error clears only on reset.
- No in_nd: all state holds; out_nd low.

## Timing
- Reset values: out_data=0, out_nd=0, out_m=0, error=0, cnt=0, acc=0, m_hold=0.
- Latency: out_nd rises the cycle after the clock edge that captures the last sample's in_nd. High exactly one cycle per block.
- out_data/out_m hold their value until the next block completes.
- Throughput: in_nd may be high every cycle. The first sample of the next block may arrive the cycle immediately after the last sample of the previous one; it loads acc directly, with no bubble and no contamination.
- error asserts the cycle after the offending in_nd edge.
- Reset mid-block: partial sum and count discarded. The first in_nd after rst_n release starts a fresh block. out_nd never fires for the aborted block.

## Structure
- Single module, no sub-modules; adder and shift inline.
- Packing convention (real in MSBs, WIDTH/2 per component) belongs in the shared fpgamath header as width macros. It is common to multiply_complex and this block. No other new shared constants.
- Estimated 120–180 lines RTL.

## Test plan
All scenarios use WIDTH=32, LOG_N=2.
- Four samples (4,8), in_nd every cycle, in_m=1 -> one out_nd pulse one cycle after the 4th sample: out_data=(4,8), out_m=1, error=0.
- Four samples (-1,0), (1,-1), (0,0), (0,0) with random in_nd gaps -> sum (0,-1) >>> 2 = (0,-1); out_nd only after the 4th sample.
- Four samples (32767,-32768) back-to-back, immediately followed by four samples (2,-2) -> two pulses exactly 4 cycles apart: (32767,-32768) then (2,-2). No overflow; the second block is uncontaminated.
- Block with in_m sequence 0,0,1,0 -> error=1 from the cycle after the 3rd sample and stays set; output still produced with out_m=0.
- Two samples (100,100), then rst_n low for one cycle asynchronously, then four samples (1,1) -> all outputs 0 during reset. Exactly one out_nd follows, with out_data=(1,1); the partial block is never output.
- Idle, in_nd=0 for 50 cycles after reset -> out_nd, out_data, error remain 0.

Source files
------------

// File: rtl/accumulate_complex_pkg.sv
// Shared constants and packing helpers for the complex accumulate stage.
// Packed complex words carry the real part in the upper half and the imaginary part in the
// lower half, both two's complement.
package accumulate_complex_pkg;

    localparam int unsigned LOG_N_MIN = 1;
    localparam int unsigned LOG_N_MAX = 8;

    // Width of one component of a packed complex word.
    function automatic int unsigned half_width(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned re_msb(input int unsigned width);
        return width - 1;
    endfunction

    function automatic int unsigned re_lsb(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned im_msb(input int unsigned width);
        return width / 2 - 1;
    endfunction

    function automatic bit log_n_legal(input int unsigned log_n);
        return (log_n >= LOG_N_MIN) && (log_n <= LOG_N_MAX);
    endfunction

endpackage

// File: rtl/accumulate_complex.sv
// Complex integrate-and-dump: sums blocks of 2^LOG_N complex samples and emits their
// floor-rounded average, together with the metadata of the first sample of each block.
// A sticky error flags any sample whose metadata differs from its block's first sample.
module accumulate_complex
    import accumulate_complex_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MWIDTH = 1,
    parameter int unsigned LOG_N  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_nd,
    input  logic [MWIDTH-1:0] in_m,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_nd,
    output logic [MWIDTH-1:0] out_m,
    output logic              error
);

    localparam int unsigned HW     = half_width(WIDTH);
    localparam int unsigned AW     = HW + LOG_N;
    localparam int unsigned RE_MSB = re_msb(WIDTH);
    localparam int unsigned RE_LSB = re_lsb(WIDTH);
    localparam int unsigned IM_MSB = im_msb(WIDTH);

    if (!log_n_legal(LOG_N) || (WIDTH % 2 != 0)) begin : g_bad_param
        $error("accumulate_complex: LOG_N must be 1..8 and WIDTH even");
    end

    logic [LOG_N-1:0]        cnt;
    logic signed [AW-1:0]    acc_re;
    logic signed [AW-1:0]    acc_im;
    logic [MWIDTH-1:0]       m_hold;

    logic signed [AW-1:0]    smp_re;
    logic signed [AW-1:0]    smp_im;
    logic signed [AW-1:0]    sum_re;
    logic signed [AW-1:0]    sum_im;
    logic                    first;
    logic                    last;

    // Sign-extend the incoming components and form the running sums.
    always_comb begin
        smp_re = {{LOG_N{in_data[RE_MSB]}}, in_data[RE_MSB:RE_LSB]};
        smp_im = {{LOG_N{in_data[IM_MSB]}}, in_data[IM_MSB:0]};
        sum_re = acc_re + smp_re;
        sum_im = acc_im + smp_im;
        first  = (cnt == '0);
        last   = &cnt;
    end

    // Block state: the first sample reloads the accumulators so back-to-back blocks never mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_re <= '0;
            acc_im <= '0;
            m_hold <= '0;
        end else if (in_nd) begin
            cnt <= cnt + LOG_N'(1);
            if (first) begin
                acc_re <= smp_re;
                acc_im <= smp_im;
                m_hold <= in_m;
            end else begin
                acc_re <= sum_re;
                acc_im <= sum_im;
            end
        end
    end

    // Dump the averaged block on the last sample; the slice above LOG_N is the arithmetic shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_nd   <= 1'b0;
            out_m    <= '0;
        end else begin
            out_nd <= in_nd && last;
            if (in_nd && last) begin
                out_data <= {sum_re[AW-1:LOG_N], sum_im[AW-1:LOG_N]};
                out_m    <= m_hold;
            end
        end
    end

    // Sticky metadata-mismatch flag; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (in_nd && !first && (in_m != m_hold)) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accumulate_complex.sv
// Bench for accumulate_complex: a block-level model (queue of samples, plain integer sums and
// floor division) is checked against the DUT every cycle, plus hand-computed literal results.
module tb_accumulate_complex;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned MWIDTH = 1;
    localparam int unsigned LOG_N  = 2;
    localparam int          N      = 1 << LOG_N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_nd = 1'b0;
    logic [MWIDTH-1:0] in_m = '0;
    logic [WIDTH-1:0]  out_data;
    logic              out_nd;
    logic [MWIDTH-1:0] out_m;
    logic              error;

    int checks = 0;
    int failures = 0;

    accumulate_complex #(
        .WIDTH  (WIDTH),
        .MWIDTH (MWIDTH),
        .LOG_N  (LOG_N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .in_m     (in_m),
        .out_data (out_data),
        .out_nd   (out_nd),
        .out_m    (out_m),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // ---------------- behavioural model ----------------
    int                q_re[$];
    int                q_im[$];
    logic [MWIDTH-1:0] q_m[$];
    logic [WIDTH-1:0]  exp_data = '0;
    logic              exp_nd = 1'b0;
    logic [MWIDTH-1:0] exp_m = '0;
    logic              exp_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int s_re;
        int s_im;
        int a_re;
        int a_im;
        if (!rst_n) begin
            q_re.delete();
            q_im.delete();
            q_m.delete();
            exp_data <= '0;
            exp_nd   <= 1'b0;
            exp_m    <= '0;
            exp_err  <= 1'b0;
        end else begin
            exp_nd <= 1'b0;
            if (in_nd) begin
                if (q_m.size() > 0 && in_m != q_m[0]) exp_err <= 1'b1;
                q_re.push_back(int'($signed(in_data[31:16])));
                q_im.push_back(int'($signed(in_data[15:0])));
                q_m.push_back(in_m);
                if (q_re.size() == N) begin
                    s_re = 0;
                    s_im = 0;
                    foreach (q_re[i]) begin
                        s_re += q_re[i];
                        s_im += q_im[i];
                    end
                    a_re = floor_div(s_re, N);
                    a_im = floor_div(s_im, N);
                    exp_data <= {a_re[15:0], a_im[15:0]};
                    exp_m    <= q_m[0];
                    exp_nd   <= 1'b1;
                    q_re.delete();
                    q_im.delete();
                    q_m.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        check("out_nd", {31'd0, out_nd}, {31'd0, exp_nd});
        check("out_data", out_data, exp_data);
        check("out_m", {31'd0, out_m}, {31'd0, exp_m});
        check("error", {31'd0, error}, {31'd0, exp_err});
        if (out_nd) begin
            pulse_cnt++;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int re, input int im, input logic [MWIDTH-1:0] m);
        @(negedge clk);
        in_data = {re[15:0], im[15:0]};
        in_nd   = 1'b1;
        in_m    = m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_nd = 1'b0;
        end
    endtask

    int p0;

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(50);
        check("idle_out_nd", {31'd0, out_nd}, 32'd0);
        check("idle_out_data", out_data, 32'd0);
        check("idle_error", {31'd0, error}, 32'd0);
        check("idle_pulses", pulse_cnt, 32'd0);

        // Constant block (4,8), in_m=1
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) send(4, 8, 1'b1);
        idle(3);
        check("blk1_model", exp_data, 32'h0004_0008);
        check("blk1_data", out_data, 32'h0004_0008);
        check("blk1_m", {31'd0, out_m}, 32'd1);
        check("blk1_pulses", pulse_cnt - p0, 32'd1);

        // Mixed signs with random gaps: (0,-1) >>> 2 = (0,-1)
        p0 = pulse_cnt;
        send(-1, 0, 1'b0);
        idle($urandom_range(0, 3));
        send(1, -1, 1'b0);
        idle($urandom_range(0, 3));
        send(0, 0, 1'b0);
        idle($urandom_range(0, 3));
        send(0, 0, 1'b0);
        idle(3);
        check("blk2_model", exp_data, 32'h0000_FFFF);
        check("blk2_data", out_data, 32'h0000_FFFF);
        check("blk2_pulses", pulse_cnt - p0, 32'd1);

        // Extremes back-to-back with a following block
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) send(32767, -32768, 1'b0);
        idle(0);
        check("blk3a_data_pending", {31'd0, exp_nd}, 32'd0);
        for (int i = 0; i < 4; i++) send(2, -2, 1'b0);
        idle(3);
        check("blk3_pulses", pulse_cnt - p0, 32'd2);
        check("blk3_spacing", last_pulse_cyc - prev_pulse_cyc, 32'd4);
        check("blk3b_data", out_data, 32'h0002_FFFE);

        // Metadata mismatch on 3rd sample
        send(1, 2, 1'b0);
        send(3, 4, 1'b0);
        check("blk4_err_before", {31'd0, error}, 32'd0);
        send(5, 6, 1'b1);
        send(7, 8, 1'b0);
        idle(3);
        check("blk4_error", {31'd0, error}, 32'd1);
        check("blk4_data", out_data, 32'h0004_0005);
        check("blk4_m", {31'd0, out_m}, 32'd0);

        // Reset mid-block
        send(100, 100, 1'b0);
        send(100, 100, 1'b0);
        @(negedge clk);
        in_nd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_data", out_data, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_out_nd", {31'd0, out_nd}, 32'd0);
        #9 rst_n = 1'b1;
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) send(1, 1, 1'b1);
        idle(4);
        check("blk5_pulses", pulse_cnt - p0, 32'd1);
        check("blk5_data", out_data, 32'h0001_0001);
        check("blk5_error", {31'd0, error}, 32'd0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
